// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment frame capture block.
// - code_t        : 5-bit character code recovered from a segment pattern
// - SEG_*         : active-low segment patterns (bit 7 = DP, 1 = off)
// - CODE_BLANK    : code for the all-off pattern
// - CODE_BAD      : code reported for any pattern not in the table
// - state_t       : stability FSM states
package seg_pkg;

    typedef logic [4:0] code_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;  // also the 'd' glyph; always decodes to 13
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_R     = 8'hAF;
    localparam logic [7:0] SEG_T     = 8'h87;
    localparam logic [7:0] SEG_US    = 8'hF7;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam code_t CODE_R     = 5'd16;
    localparam code_t CODE_T     = 5'd18;
    localparam code_t CODE_US    = 5'd19;
    localparam code_t CODE_DASH  = 5'd20;
    localparam code_t CODE_BAD   = 5'd30;
    localparam code_t CODE_BLANK = 5'd31;

    typedef enum logic [1:0] {
        WAIT,
        SETTLE,
        HELD
    } state_t;

endpackage

// File: rtl/seg_frame_capture_if.sv
// Frame output bundle of seg_frame_capture.
// - frame_codes : decoded codes, digit i in bits [5i+4:5i]
// - frame_err   : per-digit "pattern not in table" flags
// - frame_valid : frame available
// - frame_ready : consumer accepts the frame
// - overrun     : one-cycle pulse when a completed frame was dropped
// master = capture block, slave = consumer.
interface seg_frame_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic [5*NUM_DIGITS-1:0] frame_codes;
    logic [NUM_DIGITS-1:0]   frame_err;
    logic                    frame_valid;
    logic                    frame_ready;
    logic                    overrun;

    modport master (
        output frame_codes,
        output frame_err,
        output frame_valid,
        output overrun,
        input  frame_ready
    );

    modport slave (
        input  frame_codes,
        input  frame_err,
        input  frame_valid,
        input  overrun,
        output frame_ready
    );
endinterface

// File: rtl/seg_decode.sv
// Combinational 7-segment pattern decoder.
// - seg_i  : active-low segment pattern (bit 7 = DP)
// - code_o : recovered character code, CODE_BAD if unknown
// - err_o  : 1 when the pattern is not in the table
module seg_decode
    import seg_pkg::*;
(
    input  logic [7:0] seg_i,
    output code_t      code_o,
    output logic       err_o
);

    always_comb begin
        code_o = CODE_BAD;
        err_o  = 1'b0;
        case (seg_i)
            SEG_0:     code_o = 5'd0;
            SEG_1:     code_o = 5'd1;
            SEG_2:     code_o = 5'd2;
            SEG_3:     code_o = 5'd3;
            SEG_4:     code_o = 5'd4;
            SEG_5:     code_o = 5'd5;
            SEG_6:     code_o = 5'd6;
            SEG_7:     code_o = 5'd7;
            SEG_8:     code_o = 5'd8;
            SEG_9:     code_o = 5'd9;
            SEG_A:     code_o = 5'd10;
            SEG_B:     code_o = 5'd11;
            SEG_C:     code_o = 5'd12;
            SEG_D:     code_o = 5'd13;
            SEG_E:     code_o = 5'd14;
            SEG_F:     code_o = 5'd15;
            SEG_R:     code_o = CODE_R;
            SEG_T:     code_o = CODE_T;
            SEG_US:    code_o = CODE_US;
            SEG_DASH:  code_o = CODE_DASH;
            SEG_BLANK: code_o = CODE_BLANK;
            default:   err_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_frame_capture.sv
// Samples a multiplexed active-low 7-segment bus, waits for each digit's
// pattern to settle, decodes it and assembles one code per digit into a
// frame handed out over valid/ready.
// - clk, rst_n : clock, asynchronous active-low reset
// - seg_in     : active-low segment bus (bit 7 = DP)
// - dig_sel    : one-hot active-high digit strobe
// - frame_if   : frame output bundle (codes, err, valid, ready, overrun)
module seg_frame_capture
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            seg_in,
    input  logic [NUM_DIGITS-1:0] dig_sel,
    seg_frame_capture_if.master   frame_if
);

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic [7:0]              r_seg_q, ref_seg_q;
    logic [NUM_DIGITS-1:0]   r_sel_q, ref_sel_q, mask_q, mask_d;
    logic [7:0]              cnt_q, cnt_d;
    state_t                  state_q, state_d;
    logic [5*NUM_DIGITS-1:0] codes_q;
    logic [NUM_DIGITS-1:0]   err_q;
    logic                    valid_q, valid_d, overrun_q;

    wire  [5*NUM_DIGITS-1:0] slot_codes;
    wire  [NUM_DIGITS-1:0]   slot_errs;

    code_t dec_code;
    logic  dec_err;
    logic  r_onehot, ref_match, ref_load, capture;
    logic  mask_full, out_free, emit;

    seg_decode u_decode (
        .seg_i  (r_seg_q),
        .code_o (dec_code),
        .err_o  (dec_err)
    );

    assign r_onehot  = (r_sel_q != '0) && ((r_sel_q & (r_sel_q - NUM_DIGITS'(1))) == '0);
    assign ref_match = (r_seg_q == ref_seg_q) && (r_sel_q == ref_sel_q);

    // Stability FSM: any change of a one-hot sample restarts the count;
    // a non-one-hot strobe drops back to WAIT.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ref_load = 1'b0;
        capture  = 1'b0;
        case (state_q)
            WAIT: begin
                if (r_onehot) ref_load = 1'b1;
            end
            SETTLE: begin
                if (!r_onehot) begin
                    state_d = WAIT;
                end else if (ref_match) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == STABLE_LIM) begin
                        capture = 1'b1;
                        state_d = HELD;
                    end
                end else begin
                    ref_load = 1'b1;
                end
            end
            HELD: begin
                if (!r_onehot)       state_d  = WAIT;
                else if (!ref_match) ref_load = 1'b1;
            end
            default: state_d = WAIT;
        endcase
        // A fresh reference is the first stable sample; with a one-sample
        // requirement it is captured immediately.
        if (ref_load) begin
            cnt_d = 8'd1;
            if (STABLE_CYCLES == 1) begin
                capture = 1'b1;
                state_d = HELD;
            end else begin
                state_d = SETTLE;
            end
        end
    end

    // Frame hand-off. A full mask either moves to the output (if free) or
    // is dropped with an overrun pulse; either way the mask restarts, but a
    // capture in the same cycle keeps its own bit.
    assign mask_full = &mask_q;
    assign out_free  = !valid_q || frame_if.frame_ready;
    assign emit      = mask_full && out_free;

    always_comb begin
        mask_d = mask_full ? '0 : mask_q;
        if (capture) mask_d = mask_d | r_sel_q;
        valid_d = valid_q;
        if (emit)                                valid_d = 1'b1;
        else if (valid_q && frame_if.frame_ready) valid_d = 1'b0;
    end

    // Working slots: one code/err register per digit, written on capture
    // while its strobe bit is set.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
        code_t code_q;
        logic  err_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                code_q <= '0;
                err_q  <= 1'b0;
            end else if (capture && r_sel_q[gi]) begin
                code_q <= dec_code;
                err_q  <= dec_err;
            end
        end

        assign slot_codes[5*gi +: 5] = code_q;
        assign slot_errs[gi]         = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_q   <= '0;
            r_sel_q   <= '0;
            ref_seg_q <= '0;
            ref_sel_q <= '0;
            cnt_q     <= '0;
            state_q   <= WAIT;
            mask_q    <= '0;
            codes_q   <= '0;
            err_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            r_seg_q   <= seg_in;
            r_sel_q   <= dig_sel;
            if (ref_load) begin
                ref_seg_q <= r_seg_q;
                ref_sel_q <= r_sel_q;
            end
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            mask_q    <= mask_d;
            valid_q   <= valid_d;
            overrun_q <= mask_full && !out_free;
            if (emit) begin
                codes_q <= slot_codes;
                err_q   <= slot_errs;
            end
        end
    end

    assign frame_if.frame_codes = codes_q;
    assign frame_if.frame_err   = err_q;
    assign frame_if.frame_valid = valid_q;
    assign frame_if.overrun     = overrun_q;

endmodule

// File: doc/seg_frame_capture.md
Name: seg_frame_capture

Overview:
- Inverse of the hex/character segment driver. Samples a multiplexed, active-low 7-segment bus (seg[7] = DP, one digit strobe per digit) and decodes each settled pattern back to the 5-bit character code (0-F, r, d, t, _, -, blank).
- Assembles one code per digit into a frame and hands it out over a valid/ready handshake.
- Sits beside the display drivers, for display loop-back self-check and bench observation.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits, and the width of dig_sel; range 1..8.
- STABLE_CYCLES, 3, consecutive identical samples required before a digit is captured; range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_in  in  8  active-low segment bus, synchronous to clk
- dig_sel  in  NUM_DIGITS  one-hot, active-high digit strobe
- frame_codes  out  5*NUM_DIGITS  decoded codes; digit i is in bits [5i+4:5i]
- frame_err  out  NUM_DIGITS  per-digit flag: pattern was not in the table
- frame_valid  out  1  frame available
- frame_ready  in  1  consumer accepts the frame
- overrun  out  1  one-cycle pulse: a completed frame was discarded

Behaviour:
- Reset (async assert, sync release): all of the following go to 0:
  - frame_codes, frame_err, frame_valid, overrun
  - capture mask, working registers, stability counter
  - FSM goes to WAIT.
- Input stage: seg_in and dig_sel are registered once. All later timing counts from the registered values (r_seg, r_sel).
- Decode table (pattern -> code):
  - C0->0, F9->1, A4->2, B0->3, 99->4, 92->5, 82->6, F8->7
  - 80->8, 90->9, 88->A, 83->B, C6->C, A1->13, 86->E, 8E->F
  - AF->16, 87->18, F7->19, BF->20, FF->31
  - A1 always decodes to 13; code 17 is never produced.
  - Any other pattern -> code 30 with err=1.
- Stability FSM:
  - WAIT: r_sel is not one-hot. When r_sel becomes one-hot, latch ref_seg/ref_sel, set cnt=1, go to SETTLE.
  - SETTLE:
    - r_seg/r_sel equal to the reference: cnt++. When cnt reaches STABLE_CYCLES, capture and go to HELD.
    - Reference differs but r_sel is one-hot: reload the reference, cnt=1, stay in SETTLE.
    - r_sel is not one-hot: go to WAIT.
  - STABLE_CYCLES=1: capture happens in the same cycle the reference is latched. SETTLE is skipped and the FSM goes straight to HELD.
  - HELD: no further capture. Any change of r_seg or r_sel behaves as the SETTLE mismatch rules.
- Capture: writes the decoded code and err into working slot i (i = index of r_sel) and sets mask[i]. Re-capturing a slot overwrites it.
- Frame emission:
  - Condition: the mask is all ones in the cycle after the capture that completed it, and the output is free.
  - Output is free when frame_valid=0, or when frame_valid=1 and frame_ready=1 in that cycle.
  - On emission: copy the working slots to the outputs, set frame_valid=1, clear the mask.
  - Latency: last capture to frame_valid = 1 clk.
- Handshake:
  - frame_codes and frame_err stay stable while frame_valid=1 && !frame_ready.
  - frame_valid drops the cycle after acceptance unless a new frame is emitted in the same cycle (back-to-back is allowed).
- Overrun:
  - Mask full while the output is held (valid && !ready): discard the working frame, clear the mask, pulse overrun for 1 cycle.
  - The held output is untouched.
- Capture and mask-clear in the same cycle: the capture wins for its own bit.
- Reset mid-frame: the partial frame is lost and no overrun pulse is produced.

Decomposition:
- Package seg_pkg:
  - code_t (logic [4:0])
  - localparams for the 21 segment patterns, CODE_BLANK=31, CODE_BAD=30
  - the FSM state enum {WAIT, SETTLE, HELD}
- Sub-module seg_decode: combinational, seg[7:0] -> {err, code[4:0]}. It is the only place the table lives, and the testbench reuses it.

Test Plan:
- NUM_DIGITS=4, STABLE_CYCLES=3. Hold dig_sel=0001/0010/0100/1000 for 5 clks each with seg=F9, A4, B0, 99; frame_ready=1 -> frame_valid pulses once, frame_codes={4,3,2,1}, frame_err=0, asserted 1 clk after the 3rd stable sample of digit 3.
- Glitch: digit 0 shows 80 for 2 clks, then 90 for 3 clks -> slot 0 = 9. A 1-clk dig_sel=0011 in between causes no capture.
- Patterns A1, FF, 00 on digits 0..2, plus BF on digit 3 -> codes {20,30,31,13}, frame_err=0100.
- frame_ready=0 across two complete scans -> first frame held unchanged, exactly one overrun pulse, frame_valid stays 1. Raising ready then returns the first frame only.
- Back-to-back: ready=1 in the same cycle a new frame completes -> frame_valid stays high and frame_codes update the next cycle.
- Assert rst_n=0 mid-scan after 2 digits are captured -> all outputs 0 immediately. After release, a full scan is needed before frame_valid is raised.
